// File: rtl/gerenciador_vitais.sv
// gerenciador_vitais: vital-signs scheduler for the Tamagotchi core.
// A prescaler divides clk into a life tick. On each tick three saturating
// need levels are updated from the 4-bit estado code. A sticky morreu flag
// is raised when any tracked level reaches 0.
// The alegria level is only tracked when the macro VITAIS_ALEGRIA_EN is
// defined. Otherwise the alegria output is tied to MAX_NIVEL.
module gerenciador_vitais #(
  parameter int CLK_DIV   = 50_000_000,
  parameter int W         = 4,
  parameter int MAX_NIVEL = 15,
  parameter int GANHO     = 2,
  parameter int LIMIAR    = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   estado,
  output logic [W-1:0] saciedade,
  output logic [W-1:0] energia,
  output logic [W-1:0] alegria,
  output logic         tick,
  output logic         morreu,
  output logic         alerta
);

  localparam int             CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [W:0]     MAX_X    = (W+1)'(MAX_NIVEL);
  localparam logic [W:0]     GANHO_X  = (W+1)'(GANHO);
  localparam logic [W:0]     ONE_X    = (W+1)'(1);
  localparam logic [W:0]     TWO_X    = (W+1)'(2);
  localparam logic [W-1:0]   MAX_L    = W'(MAX_NIVEL);
  localparam logic [W-1:0]   LIM_L    = W'(LIMIAR);

  localparam logic [3:0] ST_DORMINDO   = 4'b0001;
  localparam logic [3:0] ST_COMENDO    = 4'b0010;
  localparam logic [3:0] ST_DANDO_AULA = 4'b0100;
  localparam logic [3:0] ST_MORTO      = 4'b1000;

  // Subtract in W+1 bits; a borrow into the top bit means the result went negative.
  function automatic logic [W-1:0] f_sub(input logic [W-1:0] v, input logic [W:0] n);
    logic [W:0] t;
    t = {1'b0, v} - n;
    return t[W] ? '0 : t[W-1:0];
  endfunction

  // Add in W+1 bits and clamp to the ceiling.
  function automatic logic [W-1:0] f_add(input logic [W-1:0] v, input logic [W:0] n);
    logic [W:0] t;
    t = {1'b0, v} + n;
    return (t > MAX_X) ? MAX_L : t[W-1:0];
  endfunction

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          r_morreu;
  logic [W-1:0]  r_sac;
  logic [W-1:0]  r_ene;
  logic [W-1:0]  w_sac_nx;
  logic [W-1:0]  w_ene_nx;
  logic          w_upd;
  logic          w_frozen;
  logic          w_ale_zero;
  logic          w_ale_low;
  logic          w_die;

  assign w_upd    = (r_cnt == CNT_LAST);
  assign w_frozen = r_morreu || (estado == ST_MORTO);

  // Next saciedade/energia values for the current estado (hold when frozen).
  always_comb begin
    w_sac_nx = r_sac;
    w_ene_nx = r_ene;
    if (!w_frozen) begin
      case (estado)
        ST_DORMINDO: begin
          w_ene_nx = f_add(r_ene, GANHO_X);
          w_sac_nx = f_sub(r_sac, ONE_X);
        end
        ST_COMENDO: begin
          w_sac_nx = f_add(r_sac, GANHO_X);
          w_ene_nx = f_sub(r_ene, ONE_X);
        end
        ST_DANDO_AULA: begin
          w_ene_nx = f_sub(r_ene, TWO_X);
          w_sac_nx = f_sub(r_sac, ONE_X);
        end
        default: begin
          w_sac_nx = f_sub(r_sac, ONE_X);
          w_ene_nx = f_sub(r_ene, ONE_X);
        end
      endcase
    end
  end

`ifdef VITAIS_ALEGRIA_EN
  logic [W-1:0] r_ale;
  logic [W-1:0] w_ale_nx;

  // Next alegria value: recovers while teaching, unchanged while sleeping or eating.
  always_comb begin
    w_ale_nx = r_ale;
    if (!w_frozen) begin
      if (estado == ST_DANDO_AULA)
        w_ale_nx = f_add(r_ale, GANHO_X);
      else if ((estado != ST_DORMINDO) && (estado != ST_COMENDO))
        w_ale_nx = f_sub(r_ale, ONE_X);
    end
  end

  // Alegria register, updated only on the life tick.
  always_ff @(posedge clk) begin
    if (rst)
      r_ale <= MAX_L;
    else if (w_upd)
      r_ale <= w_ale_nx;
  end

  assign alegria    = r_ale;
  assign w_ale_zero = (w_ale_nx == '0);
  assign w_ale_low  = (r_ale <= LIM_L);
`else
  assign alegria    = MAX_L;
  assign w_ale_zero = 1'b0;
  assign w_ale_low  = 1'b0;
`endif

  // Death is decided from the new values so reaching 0 and dying share an edge.
  assign w_die = w_upd && !w_frozen &&
                 ((w_sac_nx == '0) || (w_ene_nx == '0) || w_ale_zero);

  // Prescaler, tick pulse, levels and sticky death flag; reset wins over a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_morreu <= 1'b0;
      r_sac    <= MAX_L;
      r_ene    <= MAX_L;
    end else begin
      r_tick <= w_upd;
      r_cnt  <= w_upd ? '0 : r_cnt + CW'(1);
      if (w_upd) begin
        r_sac <= w_sac_nx;
        r_ene <= w_ene_nx;
      end
      if (w_die)
        r_morreu <= 1'b1;
    end
  end

  assign saciedade = r_sac;
  assign energia   = r_ene;
  assign tick      = r_tick;
  assign morreu    = r_morreu;
  assign alerta    = (r_sac <= LIM_L) || (r_ene <= LIM_L) || w_ale_low;

endmodule
